capture_mux_arbiter: RTL and testbench

Two-source arbiter and sequencer for the analyzer's 8-bit 2:1 capture multiplexer. It shares one downstream 8-bit sample channel between probe source 0 and probe source 1 using round-robin bursts. It drives the mux select, handshakes both sources with valid/ready, and presents a registered valid/ready stream to the capture memory writer.

---
 rtl/capture_mux_arbiter.sv | 158 +++++++++++++++
 tb/tb_capture_mux_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/capture_mux_arbiter.sv
// rtl/capture_mux_arbiter.sv - two-source round-robin burst arbiter for the 8-bit capture mux
// Optional build macro: CAPTURE_ARB_FIXED_PRIO_EN (source 0 always wins ties, no last pointer)
module capture_mux_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in0_data,
  input  logic       in0_valid,
  output logic       in0_ready,
  input  logic [7:0] in1_data,
  input  logic       in1_valid,
  output logic       in1_ready,
  output logic       sel,
  output logic [1:0] grant,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  if (BURST_LEN < 1 || BURST_LEN >= (1 << CNT_W)) begin : g_bad_cfg
    $error("capture_mux_arbiter: BURST_LEN must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W:0] BURST_CMP = BURST_LEN[CNT_W:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             room;
  logic             beat0, beat1;
  logic [CNT_W:0]   cnt_inc;
  logic             burst_done;
  logic             tie_pick1;

`ifdef CAPTURE_ARB_FIXED_PRIO_EN
  assign tie_pick1 = 1'b0;
`else
  logic last_q, last_d;
  // Source 1 wins a tie only when source 0 was the most recent grant.
  assign tie_pick1 = ~last_q;
`endif

  // The output register can take a sample when empty or being drained this cycle.
  assign room      = ~out_valid_q | out_ready;
  assign in0_ready = (state_q == GNT0) & room;
  assign in1_ready = (state_q == GNT1) & room;
  assign beat0     = in0_valid & in0_ready;
  assign beat1     = in1_valid & in1_ready;

  // Count is compared one bit wider so release is decided before any wrap.
  assign cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign burst_done = (cnt_inc == BURST_CMP);

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (|grant_q) | out_valid_q;

  // Next-state: arbitration, burst counting, release and output register load/drain.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifndef CAPTURE_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = tie_pick1 ? GNT1 : GNT0;
        end else if (in0_valid) begin
          state_d = GNT0;
        end else if (in1_valid) begin
          state_d = GNT1;
        end
        if (state_d != IDLE) begin
          cnt_d = '0;
`ifndef CAPTURE_ARB_FIXED_PRIO_EN
          last_d = (state_d == GNT1);
`endif
        end
      end
      GNT0: begin
        if (beat0) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (burst_done) state_d = IDLE;
        end else if (!in0_valid) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (beat1) begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (burst_done) state_d = IDLE;
        end else if (!in1_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat0 || beat1) begin
      out_valid_d = 1'b1;
      out_data_d  = beat1 ? in1_data : in0_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    grant_d = {state_d == GNT1, state_d == GNT0};
    if (state_d == GNT1) begin
      sel_d = 1'b1;
    end else if (state_d == GNT0) begin
      sel_d = 1'b0;
    end else begin
      sel_d = sel_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 2'b00;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
`ifndef CAPTURE_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifndef CAPTURE_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_capture_mux_arbiter.sv
// tb/tb_capture_mux_arbiter.sv - directed vector table plus streaming scoreboard for capture_mux_arbiter
module tb_capture_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in0_data, in1_data;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic       sel;
  logic [1:0] grant;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  capture_mux_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .sel       (sel),
    .grant     (grant),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ctl = {rst_n, in0_valid, in1_valid, out_ready}; flg = {sel, out_valid, in0_ready, in1_ready, busy}
  typedef struct {
    logic [3:0] ctl;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] e_grant;
    logic [4:0] e_flg;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] g, input logic [4:0] f, input logic [7:0] od);
    vec_t v;
    v.ctl = ctl; v.d0 = d0; v.d1 = d1; v.e_grant = g; v.e_flg = f; v.e_data = od;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [7:0] sbq[$];
  logic [7:0] nxt0, nxt1, exp_d;
  int src_cnt, dn_cnt, run;
  bit streaming;

  task automatic cycle_stream(input bit v0, input bit v1, input bit ordy);
    in0_valid = v0; in1_valid = v1; out_ready = ordy;
    in0_data = nxt0; in1_data = nxt1;
    #1;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("stream_unexpected_out", {24'h0, out_data}, 32'hffff_ffff);
      end else begin
        exp_d = sbq.pop_front();
        check("stream_data", {24'h0, out_data}, {24'h0, exp_d});
      end
      dn_cnt++;
    end
    if (in0_valid && in0_ready) begin
      sbq.push_back(in0_data); nxt0++; src_cnt++; run++;
    end
    if (in1_valid && in1_ready) begin
      sbq.push_back(in1_data); nxt1++; src_cnt++; run++;
    end
    if (grant == 2'b00 && run != 0) begin
      if (streaming) check("burst_len", run, 4);
      run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single source
    vecs.push_back(mk(4'b0001, 8'h00, 8'h00, 2'b00, 5'b00000, 8'h00));
    vecs.push_back(mk(4'b1101, 8'hA0, 8'h00, 2'b01, 5'b00101, 8'h00));
    vecs.push_back(mk(4'b1101, 8'hA0, 8'h00, 2'b01, 5'b01101, 8'hA0));
    vecs.push_back(mk(4'b1101, 8'hA1, 8'h00, 2'b01, 5'b01101, 8'hA1));
    vecs.push_back(mk(4'b1101, 8'hA2, 8'h00, 2'b01, 5'b01101, 8'hA2));
    vecs.push_back(mk(4'b1101, 8'hA3, 8'h00, 2'b00, 5'b01001, 8'hA3));
    vecs.push_back(mk(4'b1101, 8'hA4, 8'h00, 2'b01, 5'b00101, 8'hA3));
    vecs.push_back(mk(4'b1101, 8'hA4, 8'h00, 2'b01, 5'b01101, 8'hA4));
    vecs.push_back(mk(4'b1101, 8'hA5, 8'h00, 2'b01, 5'b01101, 8'hA5));
    vecs.push_back(mk(4'b1001, 8'h00, 8'h00, 2'b00, 5'b00000, 8'hA5));
    vecs.push_back(mk(4'b1001, 8'h00, 8'h00, 2'b00, 5'b00000, 8'hA5));
    // contention after reset
    vecs.push_back(mk(4'b0001, 8'h00, 8'h00, 2'b00, 5'b00000, 8'h00));
    vecs.push_back(mk(4'b1111, 8'h10, 8'h20, 2'b01, 5'b00101, 8'h00));
    vecs.push_back(mk(4'b1111, 8'h10, 8'h20, 2'b01, 5'b01101, 8'h10));
    vecs.push_back(mk(4'b1111, 8'h11, 8'h20, 2'b01, 5'b01101, 8'h11));
    vecs.push_back(mk(4'b1111, 8'h12, 8'h20, 2'b01, 5'b01101, 8'h12));
    vecs.push_back(mk(4'b1111, 8'h13, 8'h20, 2'b00, 5'b01001, 8'h13));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h20, 2'b10, 5'b10011, 8'h13));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h20, 2'b10, 5'b11011, 8'h20));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h21, 2'b10, 5'b11011, 8'h21));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h22, 2'b10, 5'b11011, 8'h22));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h23, 2'b00, 5'b11001, 8'h23));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h24, 2'b01, 5'b00101, 8'h23));
    vecs.push_back(mk(4'b1111, 8'h14, 8'h24, 2'b01, 5'b01101, 8'h14));
    // back-pressure on GNT1
    vecs.push_back(mk(4'b1011, 8'h15, 8'h24, 2'b00, 5'b00000, 8'h14));
    vecs.push_back(mk(4'b1011, 8'h00, 8'h24, 2'b10, 5'b10011, 8'h14));
    vecs.push_back(mk(4'b1011, 8'h00, 8'h24, 2'b10, 5'b11011, 8'h24));
    vecs.push_back(mk(4'b1010, 8'h00, 8'h25, 2'b10, 5'b11001, 8'h24));
    vecs.push_back(mk(4'b1010, 8'h00, 8'h25, 2'b10, 5'b11001, 8'h24));
    vecs.push_back(mk(4'b1010, 8'h00, 8'h25, 2'b10, 5'b11001, 8'h24));
    vecs.push_back(mk(4'b1011, 8'h00, 8'h25, 2'b10, 5'b11011, 8'h25));
    vecs.push_back(mk(4'b1011, 8'h00, 8'h26, 2'b10, 5'b11011, 8'h26));
    vecs.push_back(mk(4'b1011, 8'h00, 8'h27, 2'b00, 5'b11001, 8'h27));
    vecs.push_back(mk(4'b1001, 8'h00, 8'h00, 2'b00, 5'b10000, 8'h27));
    // early release with pending in1
    vecs.push_back(mk(4'b1101, 8'h30, 8'h00, 2'b01, 5'b00101, 8'h27));
    vecs.push_back(mk(4'b1111, 8'h30, 8'h40, 2'b01, 5'b01101, 8'h30));
    vecs.push_back(mk(4'b1111, 8'h31, 8'h40, 2'b01, 5'b01101, 8'h31));
    vecs.push_back(mk(4'b1011, 8'h32, 8'h40, 2'b00, 5'b00000, 8'h31));
    vecs.push_back(mk(4'b1011, 8'h32, 8'h40, 2'b10, 5'b10011, 8'h31));
    vecs.push_back(mk(4'b1011, 8'h32, 8'h40, 2'b10, 5'b11011, 8'h40));
    // reset mid-burst, then first tie goes to source 0; drain+load same cycle
    vecs.push_back(mk(4'b0111, 8'h32, 8'h41, 2'b00, 5'b00000, 8'h00));
    vecs.push_back(mk(4'b1111, 8'h32, 8'h41, 2'b01, 5'b00101, 8'h00));
    vecs.push_back(mk(4'b1111, 8'h32, 8'h41, 2'b01, 5'b01101, 8'h32));
    vecs.push_back(mk(4'b1111, 8'h33, 8'h41, 2'b01, 5'b01101, 8'h33));
    vecs.push_back(mk(4'b1110, 8'h34, 8'h41, 2'b01, 5'b01001, 8'h33));

    rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      {rst_n, in0_valid, in1_valid, out_ready} = vecs[i].ctl;
      in0_data = vecs[i].d0;
      in1_data = vecs[i].d1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d {grant,sel,ov,data,r0,r1,busy}", i),
            {17'h0, grant, sel, out_valid, out_data, in0_ready, in1_ready, busy},
            {17'h0, vecs[i].e_grant, vecs[i].e_flg[4:3], vecs[i].e_data, vecs[i].e_flg[2:0]});
    end

    // streaming with random back-pressure: data integrity, burst length, beat balance
    rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nxt0 = 8'h50; nxt1 = 8'hC0; src_cnt = 0; dn_cnt = 0; run = 0;
    streaming = 1'b1;
    for (int c = 0; c < 200; c++) begin
      cycle_stream(1'b1, 1'b1, $urandom_range(0, 3) != 0);
    end
    streaming = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle_stream(1'b0, 1'b0, 1'b1);
    end
    check("beat_balance", dn_cnt, src_cnt);
    check("sb_empty", sbq.size(), 0);
    check("drained_idle", {30'h0, out_valid, busy}, 32'h0);
    check("src0_progress", {31'h0, nxt0 != 8'h50}, 32'h1);
    check("src1_progress", {31'h0, nxt1 != 8'hC0}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
